// File: rtl/reg_sequencer_pkg.sv
// Shared widths, instruction field layout, opcode and FSM encodings for reg_sequencer.
package reg_sequencer_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 18;

  localparam int OP_MSB  = 17;
  localparam int OP_LSB  = 15;
  localparam int RD_MSB  = 14;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLTU = 3'b101,
    OP_LDI  = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Field order mirrors the instruction bit layout, MSB first.
  typedef struct packed {
    opcode_e           op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } instr_t;

  function automatic logic [DATA_W-1:0] get_imm(input instr_t i);
    logic [INSTR_W-1:0] raw;
    raw = i;
    return raw[IMM_MSB:IMM_LSB];
  endfunction

  function automatic logic uses_regs(input opcode_e op);
    return (op != OP_LDI) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/reg_sequencer_if.sv
// Instruction handshake plus register-file read/write port of reg_sequencer.
interface reg_sequencer_if;
  import reg_sequencer_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  logic               rf_read_enable1;
  logic               rf_read_enable2;
  logic [ADDR_W-1:0]  rf_read_address1;
  logic [ADDR_W-1:0]  rf_read_address2;
  logic [DATA_W-1:0]  rf_read_out1;
  logic [DATA_W-1:0]  rf_read_out2;

  logic               rf_write_enable;
  logic [ADDR_W-1:0]  rf_write_address;
  logic [DATA_W-1:0]  rf_write_in;

  modport slave (
    input  instr_valid, instr, rf_read_out1, rf_read_out2,
    output instr_ready, rf_read_enable1, rf_read_enable2,
           rf_read_address1, rf_read_address2,
           rf_write_enable, rf_write_address, rf_write_in
  );

  modport master (
    output instr_valid, instr, rf_read_out1, rf_read_out2,
    input  instr_ready, rf_read_enable1, rf_read_enable2,
           rf_read_address1, rf_read_address2,
           rf_write_enable, rf_write_address, rf_write_in
  );

endinterface

// File: rtl/reg_sequencer_alu8.sv
// Combinational 8-bit ALU; carry is bit 8 of a 9-bit add/subtract (borrow for SUB).
module alu8
  import reg_sequencer_pkg::*;
(
  input  opcode_e     op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  imm,
  output logic [7:0]  result,
  output logic        carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLTU: result = {7'b0, (a < b)};
      OP_LDI:  result = imm;
      // NOP output is don't-care; the sequencer keeps its previous result.
      OP_NOP:  result = '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg_sequencer.sv
// Four-state instruction sequencer: IDLE -> READ -> EXEC -> WRITE, fixed 4-cycle issue rate.
module reg_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_sequencer_if.slave    bus,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  import reg_sequencer_pkg::*;

  state_e            state, state_nxt;
  instr_t            ir, ir_nxt;
  logic [DATA_W-1:0] a_q, b_q;
  logic [7:0]        alu_result;
  logic              alu_carry;

  assign bus.instr_ready = (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    unique case (state)
      ST_IDLE: if (bus.instr_valid) begin
        state_nxt = ST_READ;
        ir_nxt    = instr_t'(bus.instr);
      end
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  alu8 u_alu (
    .op     (ir.op),
    .a      (a_q),
    .b      (b_q),
    .imm    (get_imm(ir)),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Strobes are decoded from the next state so they are clean flop outputs
  // aligned exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      ir                   <= '0;
      a_q                  <= '0;
      b_q                  <= '0;
      result               <= '0;
      carry                <= 1'b0;
      done                 <= 1'b0;
      bus.rf_read_enable1  <= 1'b0;
      bus.rf_read_enable2  <= 1'b0;
      bus.rf_read_address1 <= '0;
      bus.rf_read_address2 <= '0;
      bus.rf_write_enable  <= 1'b0;
      bus.rf_write_address <= '0;
      bus.rf_write_in      <= '0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      if (state == ST_READ) begin
        a_q <= bus.rf_read_out1;
        b_q <= bus.rf_read_out2;
      end
      if (state == ST_EXEC && ir.op != OP_NOP) begin
        result <= alu_result;
        carry  <= alu_carry;
      end
      bus.rf_read_enable1  <= (state_nxt == ST_READ) && uses_regs(ir_nxt.op);
      bus.rf_read_enable2  <= (state_nxt == ST_READ) && uses_regs(ir_nxt.op);
      bus.rf_read_address1 <= (state_nxt == ST_READ) ? ir_nxt.rs1 : '0;
      bus.rf_read_address2 <= (state_nxt == ST_READ) ? ir_nxt.rs2 : '0;
      bus.rf_write_enable  <= (state_nxt == ST_WRITE) && (ir.op != OP_NOP);
      bus.rf_write_address <= (state_nxt == ST_WRITE && ir.op != OP_NOP) ? ir.rd : '0;
      bus.rf_write_in      <= (state_nxt == ST_WRITE && ir.op != OP_NOP) ? alu_result : '0;
      done                 <= (state_nxt == ST_WRITE);
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench: reg_sequencer driving a 32x8 negedge register file.
module tb_reg_sequencer;
  import reg_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       done;
  logic [7:0] result;
  logic       carry;
  logic [7:0] ro1 = 8'h00, ro2 = 8'h00;
  logic [7:0] rf [32] = '{default: 8'h00};
  logic       saw_we9 = 1'b0;
  int         n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  reg_sequencer_if bus ();

  reg_sequencer #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .done   (done),
    .result (result),
    .carry  (carry)
  );

  assign bus.rf_read_out1 = ro1;
  assign bus.rf_read_out2 = ro2;

  always @(negedge clk) begin
    if (bus.rf_read_enable1) ro1 <= rf[bus.rf_read_address1];
    if (bus.rf_read_enable2) ro2 <= rf[bus.rf_read_address2];
    if (bus.rf_write_enable) rf[bus.rf_write_address] <= bus.rf_write_in;
    if (bus.rf_write_enable && bus.rf_write_address == 5'd9) saw_we9 <= 1'b1;
  end

  typedef struct {
    logic [17:0] ins;
    logic        ren;
    logic        we;
    logic [7:0]  res;
    logic        cy;
    logic [4:0]  rd;
    logic [7:0]  rv;
  } vec_t;

  function automatic logic [17:0] mk_r(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  function automatic logic [17:0] mk_ldi(input logic [4:0] rd, input logic [7:0] imm);
    return {3'b110, rd, 2'b00, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t = 0;
    while (!bus.instr_ready && t < 20) begin @(negedge clk); t++; end
    chk($sformatf("v%0d_ready_wait", idx), bus.instr_ready, 1);
    bus.instr = v.ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk($sformatf("v%0d_ready_read", idx), bus.instr_ready, 0);
    chk($sformatf("v%0d_ren1", idx), bus.rf_read_enable1, v.ren);
    chk($sformatf("v%0d_ren2", idx), bus.rf_read_enable2, v.ren);
    chk($sformatf("v%0d_raddr1", idx), bus.rf_read_address1, v.ins[9:5]);
    chk($sformatf("v%0d_raddr2", idx), bus.rf_read_address2, v.ins[4:0]);
    @(negedge clk);
    chk($sformatf("v%0d_exec_quiet", idx), {done, bus.rf_write_enable, bus.rf_read_enable1}, 0);
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_we", idx), bus.rf_write_enable, v.we);
    chk($sformatf("v%0d_result", idx), result, v.res);
    chk($sformatf("v%0d_carry", idx), carry, v.cy);
    if (v.we) begin
      chk($sformatf("v%0d_waddr", idx), bus.rf_write_address, v.rd);
      chk($sformatf("v%0d_wdata", idx), bus.rf_write_in, v.res);
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_back", idx), bus.instr_ready, 1);
    chk($sformatf("v%0d_done_pulse", idx), done, 0);
    chk($sformatf("v%0d_reg", idx), rf[v.rd], v.rv);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [14];
    int acc, first, second, lowc;
    tbl[0]  = '{mk_ldi(5'd3, 8'hF0),              1'b0, 1'b1, 8'hF0, 1'b0, 5'd3,  8'hF0};
    tbl[1]  = '{mk_ldi(5'd4, 8'h20),              1'b0, 1'b1, 8'h20, 1'b0, 5'd4,  8'h20};
    tbl[2]  = '{mk_r(3'b000, 5'd5, 5'd3, 5'd4),   1'b1, 1'b1, 8'h10, 1'b1, 5'd5,  8'h10};
    tbl[3]  = '{mk_r(3'b001, 5'd6, 5'd4, 5'd3),   1'b1, 1'b1, 8'h30, 1'b1, 5'd6,  8'h30};
    tbl[4]  = '{mk_r(3'b101, 5'd7, 5'd4, 5'd3),   1'b1, 1'b1, 8'h01, 1'b0, 5'd7,  8'h01};
    tbl[5]  = '{mk_r(3'b010, 5'd8, 5'd3, 5'd4),   1'b1, 1'b1, 8'h20, 1'b0, 5'd8,  8'h20};
    tbl[6]  = '{mk_r(3'b011, 5'd8, 5'd3, 5'd4),   1'b1, 1'b1, 8'hF0, 1'b0, 5'd8,  8'hF0};
    tbl[7]  = '{mk_r(3'b100, 5'd8, 5'd3, 5'd4),   1'b1, 1'b1, 8'hD0, 1'b0, 5'd8,  8'hD0};
    tbl[8]  = '{mk_r(3'b000, 5'd3, 5'd3, 5'd3),   1'b1, 1'b1, 8'hE0, 1'b1, 5'd3,  8'hE0};
    tbl[9]  = '{mk_r(3'b111, 5'd5, 5'd3, 5'd4),   1'b0, 1'b0, 8'hE0, 1'b1, 5'd5,  8'h10};
    tbl[10] = '{mk_r(3'b001, 5'd2, 5'd3, 5'd4),   1'b1, 1'b1, 8'hC0, 1'b0, 5'd2,  8'hC0};
    tbl[11] = '{mk_ldi(5'd0, 8'h5A),              1'b0, 1'b1, 8'h5A, 1'b0, 5'd0,  8'h5A};
    tbl[12] = '{mk_r(3'b000, 5'd1, 5'd0, 5'd0),   1'b1, 1'b1, 8'hB4, 1'b0, 5'd1,  8'hB4};
    tbl[13] = '{mk_r(3'b101, 5'd12, 5'd3, 5'd4),  1'b1, 1'b1, 8'h00, 1'b0, 5'd12, 8'h00};

    // Reset held with a valid instruction pending: reset must win.
    bus.instr = mk_ldi(5'd12, 8'h77);
    bus.instr_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_strobes", {bus.rf_read_enable1, bus.rf_read_enable2, bus.rf_write_enable, done}, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.instr_ready, 1);
    chk("rst_no_write", rf[12], 0);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // instr_valid held for 8 cycles: accepts only when ready, 4 cycles apart.
    acc = 0; first = -1; second = -1; lowc = 0;
    bus.instr = mk_ldi(5'd10, 8'h11);
    bus.instr_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (bus.instr_ready) begin
        acc++;
        if (first < 0) first = n; else second = n;
      end else lowc++;
      @(negedge clk);
      if (acc == 1) bus.instr = mk_ldi(5'd11, 8'h22);
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("hold_accepts", acc, 2);
    chk("hold_spacing", second - first, 4);
    chk("hold_ready_low", lowc, 6);
    chk("hold_r10", rf[10], 8'h11);
    chk("hold_r11", rf[11], 8'h22);

    // Reset during EXEC of LDI r9,0x55 aborts the write.
    bus.instr = mk_ldi(5'd9, 8'h55);
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", bus.rf_write_enable, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ready", bus.instr_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", bus.instr_ready, 1);
    repeat (4) @(negedge clk);
    chk("abort_r9", rf[9], 0);
    chk("abort_no_strobe", saw_we9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_sequencer.md
REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width; only 8 is supported.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; only 5 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port instr_valid  input  1  upstream has an instruction on instr.
REQ-006 SHALL have port instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port instr  input  18  [17:15] opcode, [14:10] rd, [9:5] rs1, [4:0] rs2, [7:0] imm (LDI only).
REQ-008 SHALL have ports rf_read_enable1 and rf_read_enable2  output  1 each  register-file read strobes.
REQ-009 SHALL have ports rf_read_address1 and rf_read_address2  output  5 each  register-file read addresses.
REQ-010 SHALL have ports rf_read_out1 and rf_read_out2  input  8 each  register-file read data.
REQ-011 SHALL have ports rf_write_enable (output, 1), rf_write_address (output, 5) and rf_write_in (output, 8) for the register-file write port.
REQ-012 SHALL have ports done (output, 1; one-cycle completion pulse), result (output, 8; last ALU result) and carry (output, 1; last carry/borrow).

Function
REQ-013 SHALL implement FSM states IDLE, READ, EXEC and WRITE.
REQ-014 In IDLE, instr_ready SHALL be 1; instr_valid=1 SHALL latch instr and move to READ.
REQ-015 In READ, the block SHALL drive rf_read_address1=rs1 and rf_read_address2=rs2 for one cycle.
REQ-016 In READ, both read enables SHALL be 1 for opcodes 000-101 and 0 for LDI and NOP; the state SHALL then move to EXEC.
REQ-017 The register file captures on the falling edge inside READ; EXEC SHALL sample rf_read_out1 (a) and rf_read_out2 (b) on the rising edge that ends READ.
REQ-018 In EXEC, the block SHALL register result and carry, then move to WRITE.
REQ-019 Opcodes SHALL be: 000 ADD (a+b, carry = bit 8); 001 SUB (a-b, carry = borrow, a<b); 010 AND; 011 OR; 100 XOR; 101 SLTU (result = {7'b0, a<b}); 110 LDI (result = imm); 111 NOP (result unchanged).
REQ-020 For opcodes 010-110, carry SHALL be 0; for NOP, carry SHALL be unchanged.
REQ-021 All arithmetic SHALL be unsigned modulo 256, and the carry bit SHALL be computed at 9 bits.
REQ-022 In WRITE, rf_write_enable SHALL be 1 for exactly one cycle, with rf_write_address=rd and rf_write_in=result, for every opcode except NOP.
REQ-023 In WRITE, done SHALL pulse for one cycle for every opcode, and the next state SHALL be IDLE.
REQ-024 Fixed latency: accept on edge k; read strobes in cycle k+1; result and carry valid from edge k+2; write enable and done in cycle k+3; instr_ready=1 again in cycle k+4.
REQ-025 instr_ready SHALL be 0 in READ, EXEC and WRITE; instr_valid in those states SHALL be ignored and the instruction not queued.
REQ-026 rd = rs1 or rd = rs2 SHALL be legal; operands SHALL be the pre-write values.
REQ-027 A back-to-back instruction SHALL observe the previous write, because the write completes on the falling edge of WRITE, before the next READ.
REQ-028 Writes to address 0 SHALL be performed like any other address (no hardwired zero).
REQ-029 Read/write strobes and addresses SHALL be registered outputs, glitch-free, and 0 outside the states stated above.

Reset
REQ-030 When rst_n=0 at a rising edge, the state SHALL become IDLE and all strobes, done, result and carry SHALL become 0.
REQ-031 On the cycle after reset, instr_ready SHALL be 1.
REQ-032 Reset asserted in READ, EXEC or WRITE SHALL abort the instruction; no rf_write_enable SHALL be issued for it.
REQ-033 Reset SHALL dominate instr_valid in the same cycle.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the FSM state encoding, the instruction field bit positions, DATA_W and ADDR_W.
REQ-035 One combinational sub-module, alu8, SHALL compute result and carry from opcode, a, b and imm; the FSM and registers SHALL stay in reg_sequencer.

Verification
REQ-036 The bench SHALL connect reg_sequencer to the team's 32x8 negedge register file, starting with all registers 0.
REQ-037 LDI r3,0xF0 then LDI r4,0x20 then ADD r5,r3,r4 -> result 0x10, carry 1, r5=0x10, done at k+3 of each instruction.
REQ-038 SUB r6,r4,r3 with r4=0x20 and r3=0xF0 -> result 0x30, carry 1; SLTU r7,r4,r3 -> r7=0x01.
REQ-039 ADD r3,r3,r3 with r3=0xF0 -> r3=0xE0, carry 1; proves operands are read before the write.
REQ-040 NOP with rd=5 -> done pulses, rf_write_enable stays 0, r5 unchanged, result unchanged.
REQ-041 instr_valid held high for 8 cycles with two instructions -> exactly two accepts, each 4 cycles apart, instr_ready low in between.
REQ-042 rst_n=0 during EXEC of LDI r9,0x55 -> no write strobe, r9 stays 0x00, instr_ready=1 on the cycle after reset.
